// File: rtl/axi_grid_port_arb.sv
// Packet-locking round-robin arbiter for one grid output port.
// Optional lock watchdog is enabled by defining AXI_GRID_ARB_WATCHDOG_EN.
module axi_grid_port_arb #(
    parameter int NUM_REQ        = 5,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               srst_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [NUM_REQ-1:0] req_last_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      gnt_idx_o,
    output logic               locked_o,
    output logic               err_o
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]        gnt_idx_q, gnt_idx_d;
    logic [IW-1:0]        pick_s;
    logic                 hs_s;

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [IW-1:0]      p);
        logic [IW-1:0] res;
        logic [IW-1:0] cand;
        logic          found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IW'((int'(p) + i) % NUM_REQ);
            if (!found && v[cand]) begin
                res   = cand;
                found = 1'b1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s = rr_pick(req_valid_i, ptr_q);
    assign hs_s   = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    state_d   = LOCKED;
                    gnt_idx_d = pick_s;
                    gnt_d     = NUM_REQ'(1) << pick_s;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                // Only the granted requester's last flag on a real handshake ends the packet.
                if (hs_s && req_last_i[gnt_idx_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IW'(1);
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_valid_o = 1'b0;
        req_ready_o = '0;
        locked_o    = 1'b0;
        case (state_q)
            LOCKED: begin
                out_valid_o = req_valid_i[gnt_idx_q];
                req_ready_o = gnt_q & {NUM_REQ{out_ready_i}};
                locked_o    = 1'b1;
            end
            default: begin
                out_valid_o = 1'b0;
            end
        endcase
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = gnt_idx_q;

`ifdef AXI_GRID_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          err_q, err_d;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    // Count stalled locked cycles, saturating at the threshold; the error is sticky.
    always_comb begin
        wd_cnt_d = '0;
        err_d    = err_q;
        if (state_q == LOCKED && !hs_s) begin
            if (wd_cnt_q != CW'(TIMEOUT_CYCLES)) begin
                wd_cnt_d = wd_cnt_q + CW'(1);
            end else begin
                wd_cnt_d = wd_cnt_q;
            end
        end else begin
            wd_cnt_d = '0;
        end
        if (wd_cnt_d == CW'(TIMEOUT_CYCLES)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
